// File: rtl/id_scan_ctrl.sv
// Identifier scanner: walks framed ASCII characters, tracks letter-led alphanumeric runs
// and emits one {start, length} record for every run whose final character is a digit.
module id_scan_ctrl #(
  parameter int POS_W = 8,
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             in_ready,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [POS_W-1:0] tok_start,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_sat,
  output logic             match,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_tok_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a valid source holds its payload stable until that transfer edge.
  typedef enum logic [1:0] {S_IDLE, S_ALPHA, S_DIGIT} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] run_start_q, run_start_d;
  logic [LEN_W-1:0] run_len_q, run_len_d, len_inc;
  logic             run_sat_q, run_sat_d, sat_inc;
  logic [CNT_W-1:0] cnt_q, cnt_after;
  logic             match_d;
  logic             emit;
  logic [POS_W-1:0] emit_start;
  logic [LEN_W-1:0] emit_len;
  logic             emit_sat;
  logic             accept, is_l, is_d, frame_end;

  assign in_ready  = !tok_valid || tok_ready;
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && in_last;
  assign is_l      = ((in_char >= 8'd65) && (in_char <= 8'd90)) ||
                     ((in_char >= 8'd97) && (in_char <= 8'd122));
  assign is_d      = (in_char >= 8'd48) && (in_char <= 8'd57);

  // Length sticks at its maximum; the sat flag records that an increment was lost.
  always_comb begin
    len_inc = run_len_q;
    sat_inc = run_sat_q;
    if (run_len_q == LEN_MAX) sat_inc = 1'b1;
    else                      len_inc = run_len_q + LEN_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    run_start_d = run_start_q;
    run_len_d   = run_len_q;
    run_sat_d   = run_sat_q;
    match_d     = match;
    emit        = 1'b0;
    emit_start  = run_start_q;
    emit_len    = run_len_q;
    emit_sat    = run_sat_q;
    if (accept) begin
      pos_d = pos_q + POS_W'(1);
      case (state_q)
        S_IDLE: begin
          if (is_l) begin
            state_d     = S_ALPHA;
            run_start_d = pos_q;
            run_len_d   = LEN_W'(1);
            run_sat_d   = 1'b0;
          end
        end
        S_ALPHA, S_DIGIT: begin
          if (is_l || is_d) begin
            state_d   = is_l ? S_ALPHA : S_DIGIT;
            run_len_d = len_inc;
            run_sat_d = sat_inc;
          end else begin
            state_d = S_IDLE;
            emit    = (state_q == S_DIGIT);
          end
        end
        default: state_d = S_IDLE;
      endcase
      match_d = (state_d == S_DIGIT);
      // The frame's last character can itself complete a token.
      if (in_last) begin
        if (state_d == S_DIGIT) begin
          emit       = 1'b1;
          emit_start = run_start_d;
          emit_len   = run_len_d;
          emit_sat   = run_sat_d;
        end
        state_d = S_IDLE;
        pos_d   = '0;
        match_d = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_after = cnt_q;
    if (emit && (cnt_q != CNT_MAX)) cnt_after = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pos_q         <= '0;
      run_start_q   <= '0;
      run_len_q     <= '0;
      run_sat_q     <= 1'b0;
      cnt_q         <= '0;
      match         <= 1'b0;
      tok_valid     <= 1'b0;
      tok_start     <= '0;
      tok_len       <= '0;
      tok_sat       <= 1'b0;
      frame_done    <= 1'b0;
      frame_tok_cnt <= '0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      run_start_q   <= run_start_d;
      run_len_q     <= run_len_d;
      run_sat_q     <= run_sat_d;
      match         <= match_d;
      cnt_q         <= frame_end ? '0 : cnt_after;
      frame_done    <= frame_end;
      frame_tok_cnt <= frame_end ? cnt_after : '0;
      if (emit) begin
        tok_valid <= 1'b1;
        tok_start <= emit_start;
        tok_len   <= emit_len;
        tok_sat   <= emit_sat;
      end else if (tok_ready) begin
        tok_valid <= 1'b0;
      end
    end
  end

endmodule
